// File: rtl/mux_rr_nway.sv
// N-channel registered stream multiplexer with round-robin or fixed-priority arbitration.
// A single output register holds the granted word until the consumer takes it.
module mux_rr_nway #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NUM_CH = 4,
  localparam int unsigned SEL_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam logic [SEL_W-1:0] LastCh = SEL_W'(NUM_CH - 1);

  logic [WIDTH-1:0]  data_q, data_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              valid_q, valid_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;

  logic [NUM_CH-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic [WIDTH-1:0]  grant_data;
  logic              load;
  logic              found;

  // Two passes: channels at or above the pointer first, then wrap to the lowest valid one.
  // In fixed-priority mode the first pass covers every channel, so the pointer drops out.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!found && in_valid[i] && (mode || (SEL_W'(i) >= ptr_q))) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = SEL_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!found && in_valid[i]) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        grant_data = grant_data | in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign load     = (|in_valid) & (~valid_q | out_ready) & rst_n;
  assign in_ready = load ? grant : '0;

  always_comb begin
    data_d  = data_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (load) begin
      data_d  = grant_data;
      sel_d   = grant_idx;
      valid_d = 1'b1;
      if (!mode) begin
        ptr_d = (grant_idx == LastCh) ? '0 : grant_idx + SEL_W'(1);
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_rr_nway.sv
// Bench for mux_rr_nway: a 4-channel and a 3-channel instance checked every cycle against
// a modulo-arithmetic reference model, plus directed scenarios with fixed expected values.
module tb_mux_rr_nway;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, mode, out_ready;

  logic [3:0]     iv_a;
  logic [4*W-1:0] id_a;
  logic [3:0]     ir_a;
  logic [W-1:0]   od_a;
  logic [1:0]     os_a;
  logic           ov_a;

  logic [2:0]     iv_b;
  logic [3*W-1:0] id_b;
  logic [2:0]     ir_b;
  logic [W-1:0]   od_b;
  logic [1:0]     os_b;
  logic           ov_b;

  mux_rr_nway #(.WIDTH(W), .NUM_CH(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .in_data(id_a), .in_valid(iv_a), .in_ready(ir_a),
    .out_data(od_a), .out_sel(os_a), .out_valid(ov_a), .out_ready(out_ready)
  );

  mux_rr_nway #(.WIDTH(W), .NUM_CH(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .in_data(id_b), .in_valid(iv_b), .in_ready(ir_b),
    .out_data(od_b), .out_sel(os_b), .out_valid(ov_b), .out_ready(out_ready)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 = 4-channel instance, 1 = 3-channel instance.
  bit         mv[2] = '{0, 0};
  logic [W-1:0] md[2] = '{16'h0, 16'h0};
  int         ms[2] = '{0, 0};
  int         mp[2] = '{0, 0};

  function automatic int nch(int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic bit valid_of(int k, int c);
    return (k == 0) ? iv_a[c] : iv_b[c];
  endfunction

  function automatic logic [W-1:0] data_of(int k, int c);
    return (k == 0) ? id_a[c*W +: W] : id_b[c*W +: W];
  endfunction

  // First valid channel found by walking forward from the start point, modulo channel count.
  function automatic int grant_of(int k);
    int base;
    int c;
    base = mode ? 0 : mp[k];
    for (int j = 0; j < nch(k); j++) begin
      c = (base + j) % nch(k);
      if (valid_of(k, c)) return c;
    end
    return -1;
  endfunction

  function automatic bit load_of(int k);
    return rst_n && (grant_of(k) >= 0) && (!mv[k] || out_ready);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check in_ready before the edge, advance the model, check outputs after it.
  task automatic cycle(string tag);
    int g[2];
    bit ld[2];
    logic [W-1:0] dat[2];
    logic [31:0] exp_rdy;
    #1;
    for (int k = 0; k < 2; k++) begin
      g[k]   = grant_of(k);
      ld[k]  = load_of(k);
      dat[k] = (g[k] >= 0) ? data_of(k, g[k]) : '0;
      exp_rdy = ld[k] ? (32'd1 << g[k]) : 32'd0;
      check({tag, "/in_ready"}, (k == 0) ? 32'(ir_a) : 32'(ir_b), exp_rdy);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mv[k] = 0; md[k] = '0; ms[k] = 0; mp[k] = 0;
      end else if (ld[k]) begin
        md[k] = dat[k]; ms[k] = g[k]; mv[k] = 1;
        if (!mode) mp[k] = (g[k] + 1) % nch(k);
      end else if (mv[k] && out_ready) begin
        mv[k] = 0;
      end
    end
    #1;
    check({tag, "/a_valid"}, 32'(ov_a), 32'(mv[0]));
    check({tag, "/a_sel"},   32'(os_a), 32'(ms[0]));
    check({tag, "/a_data"},  32'(od_a), 32'(md[0]));
    check({tag, "/b_valid"}, 32'(ov_b), 32'(mv[1]));
    check({tag, "/b_sel"},   32'(os_b), 32'(ms[1]));
    check({tag, "/b_data"},  32'(od_b), 32'(md[1]));
  endtask

  initial begin
    int seq[5];
    seq = '{0, 1, 2, 3, 0};

    // Reset held two cycles with every channel requesting.
    rst_n = 1'b0; mode = 1'b0; out_ready = 1'b1;
    iv_a = 4'hF; id_a = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    iv_b = 3'h7; id_b = {16'h0B22, 16'h0B11, 16'h0B00};
    cycle("reset0");
    cycle("reset1");
    check("reset/valid", 32'(ov_a), 32'd0);
    check("reset/data",  32'(od_a), 32'h0000);
    check("reset/sel",   32'(os_a), 32'd0);
    check("reset/ready", 32'(ir_a), 32'd0);

    // Round-robin fairness on all four channels.
    rst_n = 1'b1; iv_b = 3'h0;
    for (int i = 0; i < 5; i++) begin
      cycle("rr");
      check("rr/sel_seq",  32'(os_a), 32'(seq[i]));
      check("rr/data_seq", 32'(od_a), 32'(16'h1111 * (seq[i] + 1)));
    end

    // Fixed priority: ch1 wins over ch3 until it drops.
    mode = 1'b1; iv_a = 4'b1010;
    id_a = {16'h1234, 16'h0, 16'hABCD, 16'h0};
    for (int i = 0; i < 3; i++) begin
      cycle("fixed");
      check("fixed/ch1_sel",  32'(os_a), 32'd1);
      check("fixed/ch1_data", 32'(od_a), 32'hABCD);
    end
    iv_a = 4'b1000;
    cycle("fixed_drop");
    check("fixed/ch3_sel",  32'(os_a), 32'd3);
    check("fixed/ch3_data", 32'(od_a), 32'h1234);

    // Backpressure: hold 0xAAAA for three stalled cycles, then drain and load together.
    mode = 1'b0; iv_a = 4'b0001; id_a = {48'h0, 16'hAAAA};
    cycle("bp_load");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv_a = 4'($urandom); id_a = {$urandom, $urandom};
      cycle("bp_stall");
      check("bp/hold_data",  32'(od_a), 32'hAAAA);
      check("bp/hold_valid", 32'(ov_a), 32'd1);
      check("bp/no_ready",   32'(ir_a), 32'd0);
    end
    out_ready = 1'b1; iv_a = 4'b0100; id_a = {16'h0, 16'h5555, 32'h0};
    cycle("bp_release");
    check("bp/new_data",  32'(od_a), 32'h5555);
    check("bp/new_valid", 32'(ov_a), 32'd1);

    // Non-power-of-two wrap on the 3-channel instance.
    iv_a = 4'h0;
    iv_b = 3'b010;
    cycle("wrap_ptr");
    iv_b = 3'b101;
    cycle("wrap_hi");
    check("wrap/ch2_sel",  32'(os_b), 32'd2);
    check("wrap/ch2_data", 32'(od_b), 32'h0B22);
    cycle("wrap_lo");
    check("wrap/ch0_sel",  32'(os_b), 32'd0);

    // Reset while a word is stalled discards it.
    out_ready = 1'b0;
    cycle("stall_pre_reset");
    rst_n = 1'b0;
    cycle("reset_mid");
    check("reset_mid/b_valid", 32'(ov_b), 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) mode = 1'($urandom);
      rst_n     = ($urandom_range(0, 49) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      iv_a = 4'($urandom); id_a = {$urandom, $urandom};
      iv_b = 3'($urandom); id_b = 48'({$urandom, $urandom});
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
